reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers; ADDR_W = clog2(DEPTH), minimum 1.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads 0, ignores writes, and is never busy.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: clk_en  in  1  global advance; when 0, no state changes.
REQ-008 SHALL have ports: wr_en  in  1, wr_addr  in  ADDR_W, wr_data  in  DATA_W  (write port; completes a pending result).
REQ-009 SHALL have ports: rsv_en  in  1, rsv_addr  in  ADDR_W  (reserve destination: mark register pending).
REQ-010 SHALL have ports: rsv_ok  out  1  (combinational; reservation accepted this cycle).
REQ-011 SHALL have ports: flush  in  1  (clear all pending marks).
REQ-012 SHALL have ports: rd_addr  in  NUM_RD*ADDR_W, rd_data  out  NUM_RD*DATA_W, rd_busy  out  NUM_RD  (port i in slice i, combinational).
REQ-013 SHALL have ports: busy_cnt  out  ADDR_W+1  (registered count of pending registers).

Function
REQ-014 Write SHALL update reg[wr_addr] on the edge when clk_en & wr_en, and clear busy[wr_addr].
REQ-015 rd_data[i] SHALL equal reg[rd_addr[i]]; rd_busy[i] SHALL equal busy[rd_addr[i]].
REQ-016 rsv_ok SHALL be rsv_en & clk_en & ~flush & ~busy[rsv_addr] (register 0 with ZERO_REG=1: rsv_ok=1, no mark).
REQ-017 When rsv_ok, busy[rsv_addr] SHALL be set on the edge.
REQ-018 Same-cycle write and accepted reserve to the same address: data written, busy ends set (new producer wins).
REQ-019 A reservation of an already-busy register SHALL be refused (rsv_ok=0); no state change.
REQ-020 flush with clk_en SHALL clear every busy bit and refuse any reservation that cycle; a same-cycle write still updates data.
REQ-021 busy_cnt SHALL equal popcount(busy) after every edge: +1 on an accepted reserve, -1 on a write to a busy register, net 0 for REQ-018, 0 after flush.
REQ-022 Writes to out-of-range addresses (DEPTH not a power of 2) SHALL be ignored; reads SHALL return 0 with busy 0.
REQ-023 Write of a non-busy register SHALL update data and leave busy_cnt unchanged.

Reset
REQ-024 On rst all registers SHALL become 0, all busy bits 0, busy_cnt 0; rst overrides clk_en, wr_en, rsv_en, flush.
REQ-025 rsv_ok SHALL be 0 while rst is high.

Configuration
REQ-026 Macro REG_FILE_SB_BYPASS_EN defined: when clk_en & wr_en and rd_addr[i]==wr_addr (valid, not ZERO_REG reg 0), rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle.
REQ-027 Macro absent: reads return the pre-edge stored value and stored busy bit; no forwarding logic.

Structure
REQ-028 Package reg_file_pkg SHALL hold default DATA_W/DEPTH/NUM_RD constants and the clog2 helper.
REQ-029 Busy bits, reserve/flush logic and busy_cnt SHALL live in sub-module reg_file_sb_score; data array and read/bypass muxing in reg_file_sb.

Verification
REQ-030 Reset then read all 8 regs on both ports -> rd_data 0, rd_busy 0, busy_cnt 0.
REQ-031 Reserve r3 -> rsv_ok=1, busy_cnt 1, rd_busy=1 on r3; reserve r3 again -> rsv_ok=0, busy_cnt 1; write r3=0xDEADBEEF -> busy_cnt 0, read 0xDEADBEEF.
REQ-032 Same cycle write r5=0x12 and reserve r5 (r5 idle) -> next cycle r5=0x12, rd_busy=1, busy_cnt 1.
REQ-033 Reserve r1,r2,r4; flush with concurrent reserve r6 -> rsv_ok=0, busy_cnt 0, all busy 0.
REQ-034 Write r2=0xA5A5A5A5 while reading r2: with REG_FILE_SB_BYPASS_EN same-cycle rd_data 0xA5A5A5A5; without, old value, new value next cycle.
REQ-035 clk_en=0 with write r7=0x55 and reserve r7 -> r7 unchanged, rsv_ok=0; ZERO_REG=1 write r0=0xFF -> r0 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_RD = 2;

  // Address width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_file_sb_score.sv
// Scoreboard for the register file: per-register pending bits, reservation
// acceptance, flush handling and the registered pending count.
module reg_file_sb_score
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;
  logic [ADDR_W:0]  cnt;
  logic             wr_valid, rsv_valid, rsv_zero;

  assign wr_valid  = (32'(wr_addr) < 32'(DEPTH));
  assign rsv_valid = (32'(rsv_addr) < 32'(DEPTH));
  assign rsv_zero  = (ZERO_REG != 0) && (rsv_addr == '0);

  // A hard-wired zero register is always accepted but never marked pending.
  assign rsv_ok = ~rst & rsv_en & clk_en & ~flush &
                  (rsv_zero | (rsv_valid & ~busy_q[rsv_addr]));

  always_comb begin
    busy_d = busy_q;
    if (clk_en) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        // Clear before set so a same-cycle reserve makes the new producer win.
        if (wr_en && wr_valid) busy_d[wr_addr] = 1'b0;
        if (rsv_ok && !rsv_zero) busy_d[rsv_addr] = 1'b1;
      end
    end
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, busy_d[i]};
    end
    busy_cnt_d = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with reservation scoreboard and NUM_RD combinational read ports.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = clog2_min1(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_fire;

  reg_file_sb_score #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rsv_ok   (rsv_ok),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Register 0 stays at its reset value of zero when hard-wired.
  assign wr_fire = clk_en & wr_en & (32'(wr_addr) < 32'(DEPTH)) &
                   ~((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              ra_valid;
      logic [DATA_W-1:0] stored_data;
      logic              stored_busy;

      assign ra          = rd_addr[gi*ADDR_W +: ADDR_W];
      assign ra_valid    = (32'(ra) < 32'(DEPTH));
      assign stored_data = ra_valid ? mem_q[ra] : '0;
      assign stored_busy = ra_valid & busy[ra];

`ifdef REG_FILE_SB_BYPASS_EN
      // wr_fire already excludes invalid and hard-wired-zero addresses.
      logic hit;
      assign hit = wr_fire && (ra == wr_addr);
      assign rd_data[gi*DATA_W +: DATA_W] = hit ? wr_data : stored_data;
      assign rd_busy[gi]                  = hit ? 1'b0 : stored_busy;
`else
      assign rd_data[gi*DATA_W +: DATA_W] = stored_data;
      assign rd_busy[gi]                  = stored_busy;
`endif
    end
  endgenerate

endmodule
